// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nn_pkg
// Description : Shared definitions for the neuron MAC sequencer. Holds the
//               external ALU opcode set and the sequencer state encoding so
//               the sequencer and the ALU agree on both.
// Ports       : none (package)
// Revision    : 1.0  initial release
// ============================================================================
package nn_pkg;

    // Opcodes understood by the shared external ALU.
    typedef enum logic [2:0] {
        ALU_ADD    = 3'b000,
        ALU_MUL    = 3'b001,
        ALU_NONNEG = 3'b010,
        ALU_PASS   = 3'b111
    } alu_op_e;

    // Sequencer states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH_W = 3'd1,
        FETCH_X = 3'd2,
        MUL     = 3'd3,
        ACC     = 3'd4,
        ACT     = 3'd5,
        DONE    = 3'd6
    } state_e;

endpackage : nn_pkg
`default_nettype wire

// File: rtl/neuron_mac_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : neuron_mac_seq_if
// Description : Bundles the neuron sequencer's request, memory and ALU signals.
// Modports    : slave  - the sequencer (consumes Start/Len/BaseW/BaseX,
//                        MemRdData, AluResult; drives status, memory strobe
//                        and ALU operands)
//               master - the environment (requester, memory and ALU)
// Revision    : 1.0  initial release
// ============================================================================
interface neuron_mac_seq_if #(
    parameter int NBITS = 32,
    parameter int ADDRW = 8
);
    logic             Start;
    logic [ADDRW-1:0] Len;
    logic [ADDRW-1:0] BaseW;
    logic [ADDRW-1:0] BaseX;
    logic             Busy;
    logic             Done;
    logic [NBITS-1:0] Result;
    logic             Fire;
    logic             MemRd;
    logic [ADDRW-1:0] MemAddr;
    logic [NBITS-1:0] MemRdData;
    logic [2:0]       AluCtrl;
    logic [NBITS-1:0] AluSrcA;
    logic [NBITS-1:0] AluSrcB;
    logic [NBITS-1:0] AluResult;

    modport slave (
        input  Start, Len, BaseW, BaseX, MemRdData, AluResult,
        output Busy, Done, Result, Fire, MemRd, MemAddr,
               AluCtrl, AluSrcA, AluSrcB
    );

    modport master (
        output Start, Len, BaseW, BaseX, MemRdData, AluResult,
        input  Busy, Done, Result, Fire, MemRd, MemAddr,
               AluCtrl, AluSrcA, AluSrcB
    );

endinterface : neuron_mac_seq_if
`default_nettype wire

// File: rtl/nn_index_counter.sv
`default_nettype none
// ============================================================================
// Module      : nn_index_counter
// Description : Pair index counter for the neuron sequencer. Latches the run
//               length and both base addresses on load, steps the index on
//               inc, forms the weight/input addresses (wrapping modulo
//               2^ADDRW) and flags the final pair.
// Ports       : clk, reset          clock, async active-high reset
//               load_i              latch len/bases, clear index
//               inc_i               advance index
//               len_i, base_w_i,
//               base_x_i            run length and base addresses
//               addr_w_o, addr_x_o  current weight / input address
//               last_o              index is the final pair (Len-1)
// Revision    : 1.0  initial release
// ============================================================================
module nn_index_counter #(
    parameter int ADDRW = 8
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             load_i,
    input  wire logic             inc_i,
    input  wire logic [ADDRW-1:0] len_i,
    input  wire logic [ADDRW-1:0] base_w_i,
    input  wire logic [ADDRW-1:0] base_x_i,
    output logic      [ADDRW-1:0] addr_w_o,
    output logic      [ADDRW-1:0] addr_x_o,
    output logic                  last_o
);

    localparam logic [ADDRW-1:0] c_ONE = {{(ADDRW-1){1'b0}}, 1'b1};

    logic [ADDRW-1:0] idx_q;
    logic [ADDRW-1:0] len_q;
    logic [ADDRW-1:0] base_w_q;
    logic [ADDRW-1:0] base_x_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q    <= '0;
            len_q    <= '0;
            base_w_q <= '0;
            base_x_q <= '0;
        end else if (load_i) begin
            idx_q    <= '0;
            len_q    <= len_i;
            base_w_q <= base_w_i;
            base_x_q <= base_x_i;
        end else if (inc_i) begin
            idx_q    <= idx_q + c_ONE;
        end
    end

    // ADDRW-bit adders give the required modulo-2^ADDRW wrap for free.
    assign addr_w_o = base_w_q + idx_q;
    assign addr_x_o = base_x_q + idx_q;
    assign last_o   = (idx_q == (len_q - c_ONE));

endmodule : nn_index_counter
`default_nettype wire

// File: rtl/neuron_mac_seq.sv
`default_nettype none
// ============================================================================
// Module      : neuron_mac_seq
// Description : Sequencer for one neuron evaluation: fetches Len weight/input
//               pairs from memory, multiplies and accumulates them through a
//               shared external ALU, then evaluates a non-negative activation.
//               Per pair: FETCH_W, FETCH_X, MUL, ACC (4 cycles); then ACT and
//               DONE, so Done rises 4*Len+2 cycles after the Start edge.
// Ports       : clk    rising-edge clock
//               reset  asynchronous active-high reset
//               bus    neuron_mac_seq_if.slave: Start/Len/BaseW/BaseX request,
//                      Busy/Done/Result/Fire status, MemRd/MemAddr/MemRdData
//                      memory port, AluCtrl/AluSrcA/AluSrcB/AluResult ALU port
// Revision    : 1.0  initial release
// ============================================================================
module neuron_mac_seq
    import nn_pkg::*;
#(
    parameter int NBITS = 32,
    parameter int ADDRW = 8
) (
    input  wire logic        clk,
    input  wire logic        reset,
    neuron_mac_seq_if.slave  bus
);

    state_e           state_q, state_d;
    logic [NBITS-1:0] acc_q;
    logic [NBITS-1:0] wreg_q;
    logic [NBITS-1:0] prod_q;
    logic [NBITS-1:0] result_q;
    logic             fire_reg_q;
    logic             fire_q;
    logic             done_q;

    // Combinational controls from the next-state process.
    logic             ctr_load;
    logic             ctr_inc;
    logic             mem_rd;
    logic [ADDRW-1:0] mem_addr;
    alu_op_e          alu_ctrl;
    logic [NBITS-1:0] alu_a;
    logic [NBITS-1:0] alu_b;

    logic [ADDRW-1:0] addr_w;
    logic [ADDRW-1:0] addr_x;
    logic             last_pair;

    nn_index_counter #(
        .ADDRW    (ADDRW)
    ) u_index_counter (
        .clk      (clk),
        .reset    (reset),
        .load_i   (ctr_load),
        .inc_i    (ctr_inc),
        .len_i    (bus.Len),
        .base_w_i (bus.BaseW),
        .base_x_i (bus.BaseX),
        .addr_w_o (addr_w),
        .addr_x_o (addr_x),
        .last_o   (last_pair)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and per-state outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        ctr_load = 1'b0;
        ctr_inc  = 1'b0;
        mem_rd   = 1'b0;
        mem_addr = '0;
        alu_ctrl = ALU_PASS;
        alu_a    = '0;
        alu_b    = '0;

        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    ctr_load = 1'b1;
                    state_d  = (bus.Len == '0) ? ACT : FETCH_W;
                end
            end
            FETCH_W: begin
                mem_rd   = 1'b1;
                mem_addr = addr_w;
                state_d  = FETCH_X;
            end
            FETCH_X: begin
                // Weight read data arrives this cycle; input read issued now.
                mem_rd   = 1'b1;
                mem_addr = addr_x;
                state_d  = MUL;
            end
            MUL: begin
                // Input read data arrives this cycle and feeds the ALU directly.
                alu_ctrl = ALU_MUL;
                alu_a    = wreg_q;
                alu_b    = bus.MemRdData;
                state_d  = ACC;
            end
            ACC: begin
                alu_ctrl = ALU_ADD;
                alu_a    = acc_q;
                alu_b    = prod_q;
                ctr_inc  = 1'b1;
                state_d  = last_pair ? ACT : FETCH_W;
            end
            ACT: begin
                alu_ctrl = ALU_NONNEG;
                alu_a    = acc_q;
                state_d  = DONE;
            end
            DONE: begin
                state_d  = IDLE;
            end
            default: begin
                state_d  = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q      <= '0;
            wreg_q     <= '0;
            prod_q     <= '0;
            fire_reg_q <= 1'b0;
            result_q   <= '0;
            fire_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= (state_q == DONE);
            case (state_q)
                IDLE:    if (bus.Start) acc_q <= '0;
                FETCH_X: wreg_q     <= bus.MemRdData;
                MUL:     prod_q     <= bus.AluResult;
                ACC:     acc_q      <= bus.AluResult;
                ACT:     fire_reg_q <= bus.AluResult[0];
                DONE: begin
                    // Published values hold until the next evaluation ends.
                    result_q <= acc_q;
                    fire_q   <= fire_reg_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.Busy    = (state_q != IDLE);
    assign bus.Done    = done_q;
    assign bus.Result  = result_q;
    assign bus.Fire    = fire_q;
    assign bus.MemRd   = mem_rd;
    assign bus.MemAddr = mem_addr;
    assign bus.AluCtrl = alu_ctrl;
    assign bus.AluSrcA = alu_a;
    assign bus.AluSrcB = alu_b;

endmodule : neuron_mac_seq
`default_nettype wire

// File: tb/tb_neuron_mac_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_neuron_mac_seq
// Description : Self-checking bench for neuron_mac_seq. Provides a behavioural
//               memory (one-cycle read latency) and ALU, a dot-product
//               reference model, a scoreboard queue of expected completions
//               and a monitor that checks each Done against it.
// Revision    : 1.0  initial release
// ============================================================================
module tb_neuron_mac_seq;

    localparam int NBITS = 32;
    localparam int ADDRW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    neuron_mac_seq_if #(.NBITS(NBITS), .ADDRW(ADDRW)) bus ();

    neuron_mac_seq #(
        .NBITS (NBITS),
        .ADDRW (ADDRW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ------------------------------------------------------------------
    // Environment: memory and ALU
    // ------------------------------------------------------------------
    logic [NBITS-1:0] mem [256];

    always @(posedge clk) begin
        if (bus.MemRd) bus.MemRdData <= mem[bus.MemAddr];
    end

    always_comb begin
        case (bus.AluCtrl)
            3'b000:  bus.AluResult = bus.AluSrcA + bus.AluSrcB;
            3'b001:  bus.AluResult = bus.AluSrcA * bus.AluSrcB;
            3'b010:  bus.AluResult = {{(NBITS-1){1'b0}}, ~bus.AluSrcA[NBITS-1]};
            default: bus.AluResult = bus.AluSrcA;
        endcase
    end

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    typedef struct {
        logic [NBITS-1:0] result;
        logic             fire;
        int               done_cyc;
    } exp_t;

    exp_t             sb[$];
    logic [ADDRW-1:0] rd_log[$];
    logic [2:0]       ctrl_log[$];
    int               cyc      = 0;
    int               done_cnt = 0;
    int               checks   = 0;
    int               errors   = 0;
    exp_t             mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: logs bus activity and scores every Done against the queue.
    always @(negedge clk) begin
        if (bus.MemRd === 1'b1)     rd_log.push_back(bus.MemAddr);
        if (bus.AluCtrl !== 3'b111) ctrl_log.push_back(bus.AluCtrl);
        if (bus.Done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("result", 64'(bus.Result), 64'(mon_e.result));
                chk("fire",   64'(bus.Fire),   64'(mon_e.fire));
                chk("done_latency", 64'(cyc),  64'(mon_e.done_cyc));
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model: plain signed dot product, truncated to NBITS.
    // ------------------------------------------------------------------
    function automatic exp_t model(input int len, input logic [7:0] bw, input logic [7:0] bx);
        logic signed [NBITS-1:0] acc;
        logic [7:0]              aw, ax;
        exp_t                    e;
        acc = '0;
        for (int k = 0; k < len; k++) begin
            aw  = bw + 8'(k);
            ax  = bx + 8'(k);
            acc = acc + $signed(mem[aw]) * $signed(mem[ax]);
        end
        e.result   = acc;
        e.fire     = (acc >= 0);
        e.done_cyc = 0;
        return e;
    endfunction

    task automatic run(input int len, input logic [7:0] bw, input logic [7:0] bx, input bit expect_done);
        exp_t e;
        @(negedge clk);
        rd_log.delete();
        ctrl_log.delete();
        bus.Start = 1'b1;
        bus.Len   = 8'(len);
        bus.BaseW = bw;
        bus.BaseX = bx;
        if (expect_done) begin
            e = model(len, bw, bx);
            e.done_cyc = cyc + 1 + 4 * len + 2;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.Start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_result"},  64'(bus.Result),  64'd0);
        chk({tag, "_fire"},    64'(bus.Fire),    64'd0);
        chk({tag, "_done"},    64'(bus.Done),    64'd0);
        chk({tag, "_busy"},    64'(bus.Busy),    64'd0);
        chk({tag, "_memrd"},   64'(bus.MemRd),   64'd0);
        chk({tag, "_memaddr"}, 64'(bus.MemAddr), 64'd0);
        chk({tag, "_aluctrl"}, 64'(bus.AluCtrl), 64'h7);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int d0;
        int seen;
        int n;
        logic [NBITS-1:0] tmp;

        reset     = 1'b1;
        bus.Start = 1'b0;
        bus.Len   = '0;
        bus.BaseW = '0;
        bus.BaseX = '0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;

        repeat (2) @(negedge clk);
        chk_cleared("reset");
        reset = 1'b0;

        // Len=3, W={2,-1,4}, X={5,3,1} -> 11, Fire=1, 14 cycles.
        mem[8'h10] = 2;  mem[8'h11] = -1; mem[8'h12] = 4;
        mem[8'h20] = 5;  mem[8'h21] = 3;  mem[8'h22] = 1;
        run(3, 8'h10, 8'h20, 1'b1);
        wait_idle();
        chk("dir3_result", 64'(bus.Result), 64'd11);
        chk("dir3_fire",   64'(bus.Fire),   64'd1);
        chk("dir3_nreads", 64'(rd_log.size()), 64'd6);
        if (rd_log.size() == 6) begin
            chk("dir3_addr0", 64'(rd_log[0]), 64'h10);
            chk("dir3_addr1", 64'(rd_log[1]), 64'h20);
            chk("dir3_addr4", 64'(rd_log[4]), 64'h12);
            chk("dir3_addr5", 64'(rd_log[5]), 64'h22);
        end

        // Len=2, W={-3,2}, X={4,1} -> -10, Fire=0; ALU ops MUL,ADD per pair.
        mem[8'h30] = -3; mem[8'h31] = 2;
        mem[8'h40] = 4;  mem[8'h41] = 1;
        run(2, 8'h30, 8'h40, 1'b1);
        wait_idle();
        tmp = -10;
        chk("dir2_result", 64'(bus.Result), 64'(tmp));
        chk("dir2_fire",   64'(bus.Fire),   64'd0);
        chk("dir2_nops",   64'(ctrl_log.size()), 64'd5);
        if (ctrl_log.size() == 5) begin
            chk("dir2_op0", 64'(ctrl_log[0]), 64'h1);
            chk("dir2_op1", 64'(ctrl_log[1]), 64'h0);
            chk("dir2_op2", 64'(ctrl_log[2]), 64'h1);
            chk("dir2_op3", 64'(ctrl_log[3]), 64'h0);
            chk("dir2_op4", 64'(ctrl_log[4]), 64'h2);
        end

        // Len=0 -> 2 cycles, Result=0, Fire=1, no memory reads.
        run(0, 8'h55, 8'h66, 1'b1);
        wait_idle();
        chk("len0_result", 64'(bus.Result),    64'd0);
        chk("len0_fire",   64'(bus.Fire),      64'd1);
        chk("len0_memrd",  64'(rd_log.size()), 64'd0);

        // Weight addresses wrap past 0xFF.
        run(3, 8'hFE, 8'h80, 1'b1);
        wait_idle();
        chk("wrap_nreads", 64'(rd_log.size()), 64'd6);
        if (rd_log.size() == 6) begin
            chk("wrap_w0", 64'(rd_log[0]), 64'hFE);
            chk("wrap_w1", 64'(rd_log[2]), 64'hFF);
            chk("wrap_w2", 64'(rd_log[4]), 64'h00);
        end

        // Start pulses and Len/Base changes while busy are ignored.
        d0 = done_cnt;
        run(2, 8'h30, 8'h40, 1'b1);
        chk("busy_flag", 64'(bus.Busy), 64'd1);
        for (int k = 0; k < 3; k++) begin
            bus.Start = 1'b1;
            bus.Len   = 8'd7;
            bus.BaseW = 8'h99;
            bus.BaseX = 8'h9A;
            @(negedge clk);
            bus.Start = 1'b0;
        end
        wait_idle();
        repeat (20) @(negedge clk);
        chk("busy_single_done", 64'(done_cnt - d0), 64'd1);
        chk("busy_result", 64'(bus.Result), 64'(tmp));

        // Reset during MUL of the second pair aborts with no Done.
        d0 = done_cnt;
        run(3, 8'h10, 8'h20, 1'b0);
        seen = 0;
        n    = 0;
        while (seen < 2 && n < 100) begin
            @(negedge clk);
            n++;
            if (bus.AluCtrl == 3'b001) seen++;
        end
        chk("abort_found_mul2", 64'(seen), 64'd2);
        #1 reset = 1'b1;
        #1 chk_cleared("abort");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);

        mem[8'hA0] = 7;
        mem[8'hB0] = 6;
        run(1, 8'hA0, 8'hB0, 1'b1);
        wait_idle();
        chk("post_reset_result", 64'(bus.Result), 64'd42);

        // Randomized runs over fully random memory contents.
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        for (int r = 0; r < 12; r++) begin
            run($urandom_range(0, 6), 8'($urandom), 8'($urandom), 1'b1);
            wait_idle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_neuron_mac_seq
`default_nettype wire

// File: doc/neuron_mac_seq.md
NEURON_MAC_SEQ -- requirements
Module: neuron_mac_seq

Interface
REQ-001 Parameter NBITS, default 32, sets the data and accumulator width.
REQ-002 Parameter ADDRW, default 8, sets the memory address width.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
REQ-004 Ports (name  direction  width  meaning), listed in the order below:
- Start  in  1  request one neuron evaluation.
- Len  in  ADDRW  number of weight/input pairs (0 allowed).
- BaseW  in  ADDRW  weight vector base address.
- BaseX  in  ADDRW  input vector base address.
- Busy  out  1  evaluation in progress.
- Done  out  1  one-cycle completion pulse.
- Result  out  NBITS  signed accumulated dot product.
- Fire  out  1  activation result (1 if Result non-negative).
- MemRd  out  1  memory read strobe.
- MemAddr  out  ADDRW  memory read address.
- MemRdData  in  NBITS  read data, valid the cycle after MemRd.
- AluCtrl  out  3  shared ALU op: 000 add, 001 mul, 010 set-if-non-negative, 111 pass A.
- AluSrcA  out  NBITS  ALU operand A.
- AluSrcB  out  NBITS  ALU operand B.
- AluResult  in  NBITS  combinational ALU result for the current AluCtrl/AluSrcA/AluSrcB.

Function
REQ-005 The FSM SHALL use the states IDLE, FETCH_W, FETCH_X, MUL, ACC, ACT and DONE.
REQ-006 In IDLE, a sampled Start=1 SHALL latch Len, BaseW and BaseX, clear index i and Acc, and go to FETCH_W; if Len=0 it SHALL go to ACT instead.
REQ-007 In FETCH_W, the block SHALL drive MemRd=1 and MemAddr=BaseW+i.
REQ-008 In FETCH_X, the block SHALL drive MemRd=1 and MemAddr=BaseX+i, and capture MemRdData into WReg.
REQ-009 In MUL, the block SHALL drive AluCtrl=001, AluSrcA=WReg and AluSrcB=MemRdData, and capture AluResult into Prod.
REQ-010 In ACC, the block SHALL drive AluCtrl=000, AluSrcA=Acc and AluSrcB=Prod, and capture AluResult into Acc; i SHALL increment; the next state SHALL be ACT if i==Len-1, else FETCH_W.
REQ-011 In ACT, the block SHALL drive AluCtrl=010 and AluSrcA=Acc, and capture AluResult[0] into FireReg.
REQ-012 In DONE, Done SHALL be 1 for exactly one cycle, Result and Fire SHALL update from Acc and FireReg, and the next state SHALL be IDLE.
REQ-013 In all other states, AluCtrl SHALL be 111, AluSrcA/AluSrcB SHALL be 0, and MemRd SHALL be 0.
REQ-014 Latency from the Start-accept edge to Done SHALL be 4*Len+2 cycles; Len=0 gives 2.
REQ-015 Busy SHALL be 1 in every state except IDLE; Start SHALL be ignored while Busy=1.
REQ-016 Address arithmetic SHALL wrap modulo 2^ADDRW.
REQ-017 Product and sum SHALL be the ALU's NBITS-truncated two's-complement values; no saturation.
REQ-018 Result and Fire SHALL hold their values until the next DONE.
REQ-019 Changes on Len, BaseW or BaseX while Busy=1 SHALL have no effect.

Reset
REQ-020 reset SHALL force the FSM to IDLE and clear i, Acc, WReg, Prod and FireReg.
REQ-021 reset SHALL clear the outputs Result, Fire, Done, Busy, MemRd and MemAddr, and set AluCtrl=111.
REQ-022 A reset asserted mid-evaluation SHALL abort the evaluation with no Done pulse; the first Start after reset is released SHALL run normally.

Structure
REQ-023 The ALU opcodes (ADD=000, MUL=001, NONNEG=010, PASS=111) and the FSM state encoding SHALL live in a shared package, nn_pkg, so the sequencer and the ALU agree.
REQ-024 One sub-module, nn_index_counter (i counter, terminal compare against Len, address adders), SHALL be used; the ALU itself SHALL stay external and be reached only through the Alu* ports.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Len=3, W={2,-1,4}, X={5,3,1} -> Done 14 cycles after Start; Result=11, Fire=1.
- Len=2, W={-3,2}, X={4,1} -> Result=-10, Fire=0; AluCtrl sequence per pair is 001 then 000.
- Len=0 -> Done 2 cycles after Start; Result=0, Fire=1; MemRd never asserted.
- BaseW=0xFE, Len=3 -> weight addresses 0xFE, 0xFF, 0x00.
- Start pulsed during Busy, and Len changed mid-run -> run unaffected, exactly one Done.
- reset asserted in MUL of pair 2 -> outputs cleared immediately, no Done; the following Start with Len=1, W=7, X=6 gives Result=42.
